// File: rtl/spm_pkg.sv
// Shared definitions for the serial-product deserializer.
//   SPM_WIDTH         : default multiplicand width; products are 2*SPM_WIDTH bits
//   spm_deser_state_t : deserializer FSM states
package spm_pkg;

  localparam int SPM_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } spm_deser_state_t;

endpackage

// File: rtl/spm_prod_deser.sv
// Collects the LSB-first serial product stream of an spm multiplier array
// into a parallel word and holds it behind a valid/ready handshake.
//
// Parameters:
//   WIDTH       : multiplicand width; product width PW = 2*WIDTH
// Ports:
//   clk         : clock, all state changes on the rising edge
//   rst         : asynchronous active-low reset
//   start       : one-cycle pulse, p carries product bit 0 in that cycle
//   p           : serial product bit, LSB first
//   busy        : high while bits are being captured
//   prod_valid  : high while a completed product is held
//   prod_ready  : consumer accepts prod when high together with prod_valid
//   prod        : assembled product, stable while prod_valid is high
//   overrun     : sticky flag, set when a start had to be dropped
//   prod_parity : XOR of all prod bits (only with SPM_DESER_PARITY_EN defined)
//
// Build option: define SPM_DESER_PARITY_EN to add the prod_parity output.
module spm_prod_deser
  import spm_pkg::*;
#(
  parameter int WIDTH = SPM_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               p,
  output logic               busy,
  output logic               prod_valid,
  input  logic               prod_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               overrun
`ifdef SPM_DESER_PARITY_EN
  ,
  output logic               prod_parity
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = $clog2(PW);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(PW - 1);

  spm_deser_state_t state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    prod_nxt;
  logic             load_first;
  logic             cap_bit;
  logic             drop_start;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and datapath controls. A start taken in HOLD together with the
  // handshake reloads bit 0 directly, so back-to-back products lose no cycle.
  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    cap_bit    = 1'b0;
    drop_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_first = 1'b1;
          state_nxt  = CAPTURE;
        end
      end
      CAPTURE: begin
        cap_bit    = 1'b1;
        drop_start = start;
        if (cnt == LAST_BIT) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (prod_ready) begin
          if (start) begin
            load_first = 1'b1;
            state_nxt  = CAPTURE;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          drop_start = start;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Only the addressed bit changes; the rest of prod keeps its old value.
  always_comb begin
    prod_nxt = prod;
    if (load_first) begin
      prod_nxt[0] = p;
    end else if (cap_bit) begin
      prod_nxt[cnt[IW-1:0]] = p;
    end
  end

  // Product word and bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod <= '0;
      cnt  <= '0;
    end else begin
      prod <= prod_nxt;
      if (load_first) begin
        cnt <= CW'(1);
      end else if (cap_bit) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Sticky overrun flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (drop_start) begin
      overrun <= 1'b1;
    end
  end

`ifdef SPM_DESER_PARITY_EN
  // Parity is taken from the next prod value so it lands in the same cycle as prod.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_parity <= 1'b0;
    end else begin
      prod_parity <= ^prod_nxt;
    end
  end
`endif

  assign busy       = (state == CAPTURE);
  assign prod_valid = (state == HOLD);

endmodule

// File: tb/tb_spm_prod_deser.sv
// Self-checking bench for spm_prod_deser at WIDTH=4 (8-bit products).
// Expected products come from x*y arithmetic; the serial stream is that
// product sent LSB first.
module tb_spm_prod_deser;

  localparam int WIDTH = 4;
  localparam int PW    = 2 * WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          p;
  logic          prod_ready;
  logic          busy;
  logic          prod_valid;
  logic [PW-1:0] prod;
  logic          overrun;
`ifdef SPM_DESER_PARITY_EN
  logic          prod_parity;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spm_prod_deser #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .p          (p),
    .busy       (busy),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod       (prod),
    .overrun    (overrun)
`ifdef SPM_DESER_PARITY_EN
    ,
    .prod_parity(prod_parity)
`endif
  );

  function automatic logic [PW-1:0] ref_product(input int x, input int y);
    return PW'(x * y);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends a full product LSB first; extra_start >= 0 adds a stray start at that bit.
  task automatic drive_stream(input logic [PW-1:0] val, input int extra_start);
    for (int i = 0; i < PW; i++) begin
      start = (i == 0) || (i == extra_start);
      p     = val[i];
      tick();
    end
    start = 1'b0;
    p     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; p = 1'b0; prod_ready = 1'b0;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (prod_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", prod_valid); end
    checks++; if (prod !== '0) begin errors++; $display("[TB] FAIL reset_prod: got %h expected 00", prod); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_start: busy got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    logic [PW-1:0] exp;
    exp = ref_product(5, 3);
    prod_ready = 1'b1;
    start = 1'b1; p = exp[0];
    tick();
    for (int i = 1; i < PW; i++) begin
      checks++;
      if (busy !== 1'b1 || prod_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_timing bit %0d: busy/valid got %b%b expected 10", i, busy, prod_valid);
      end
      start = 1'b0; p = exp[i];
      tick();
    end
    p = 1'b0;
    checks++; if (prod_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", prod_valid); end
    checks++; if (prod !== exp) begin errors++; $display("[TB] FAIL basic_prod: got %h expected %h", prod, exp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 0", busy); end
    tick();
    checks++; if (prod_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drop: got %b expected 0", prod_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL basic_overrun: got %b expected 0", overrun); end
    prod_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] exp;
    exp = ref_product(15, 15);
    prod_ready = 1'b0;
    drive_stream(exp, -1);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (prod_valid !== 1'b1 || prod !== exp) begin
        errors++;
        $display("[TB] FAIL hold_stable cycle %0d: valid %b prod %h expected 1 %h", k, prod_valid, prod, exp);
      end
      tick();
    end
    prod_ready = 1'b1;
    checks++; if (prod_valid !== 1'b1 || prod !== exp) begin errors++; $display("[TB] FAIL hold_last: valid %b prod %h expected 1 %h", prod_valid, prod, exp); end
    tick();
    prod_ready = 1'b0;
    checks++; if (prod_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_to_idle: valid/busy got %b%b expected 00", prod_valid, busy); end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] first, second;
    first  = ref_product(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    second = ref_product(2, 3);
    prod_ready = 1'b0;
    drive_stream(first, -1);
    checks++; if (prod !== first) begin errors++; $display("[TB] FAIL b2b_first: got %h expected %h", prod, first); end
    start = 1'b1; p = second[0]; prod_ready = 1'b1;
    tick();
    prod_ready = 1'b0;
    checks++; if (busy !== 1'b1 || prod_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_restart: busy/valid got %b%b expected 10", busy, prod_valid); end
    for (int i = 1; i < PW; i++) begin
      start = 1'b0; p = second[i];
      tick();
    end
    p = 1'b0;
    checks++; if (prod_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid: got %b expected 1", prod_valid); end
    checks++; if (prod !== second) begin errors++; $display("[TB] FAIL b2b_prod: got %h expected %h", prod, second); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun: got %b expected 0", overrun); end
    prod_ready = 1'b1;
    tick();
    prod_ready = 1'b0;
  endtask

  task automatic test_overrun();
    logic [PW-1:0] exp;
    exp = ref_product(int'($urandom_range(1, 15)), int'($urandom_range(1, 15)));
    prod_ready = 1'b0;
    drive_stream(exp, 3);
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_capture: got %b expected 1", overrun); end
    checks++; if (prod_valid !== 1'b1 || prod !== exp) begin errors++; $display("[TB] FAIL ovr_prod: valid %b prod %h expected 1 %h", prod_valid, prod, exp); end
    start = 1'b1; p = ~exp[0];
    tick();
    start = 1'b0; p = 1'b0;
    checks++; if (prod_valid !== 1'b1 || prod !== exp || busy !== 1'b0) begin errors++; $display("[TB] FAIL ovr_hold: valid %b busy %b prod %h expected 1 0 %h", prod_valid, busy, prod, exp); end
    prod_ready = 1'b1;
    tick();
    prod_ready = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_mid_reset();
    logic [PW-1:0] partial, exp;
    partial = ref_product(int'($urandom_range(1, 15)), int'($urandom_range(1, 15))) | 8'h01;
    exp     = ref_product(5, 3);
    prod_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start = (i == 0); p = partial[i];
      tick();
    end
    start = 1'b0; p = partial[5];
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || prod_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ctrl: busy/valid got %b%b expected 00", busy, prod_valid); end
    checks++; if (prod !== '0) begin errors++; $display("[TB] FAIL mid_reset_prod: got %h expected 00", prod); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_overrun: got %b expected 0", overrun); end
    tick();
    rst = 1'b1;
    prod_ready = 1'b0;
    drive_stream(exp, -1);
    checks++; if (prod_valid !== 1'b1 || prod !== exp) begin errors++; $display("[TB] FAIL post_reset_prod: valid %b prod %h expected 1 %h", prod_valid, prod, exp); end
    prod_ready = 1'b1;
    tick();
    prod_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [PW-1:0] exp;
    int            wait_cycles;
    for (int n = 0; n < 20; n++) begin
      exp = ref_product(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      wait_cycles = int'($urandom_range(0, 3));
      prod_ready = 1'b0;
      drive_stream(exp, -1);
      for (int k = 0; k <= wait_cycles; k++) begin
        checks++;
        if (prod_valid !== 1'b1 || prod !== exp) begin
          errors++;
          $display("[TB] FAIL rand_prod %0d: valid %b prod %h expected 1 %h", n, prod_valid, prod, exp);
        end
`ifdef SPM_DESER_PARITY_EN
        checks++;
        if (prod_parity !== ^exp) begin
          errors++;
          $display("[TB] FAIL rand_parity %0d: got %b expected %b", n, prod_parity, ^exp);
        end
`endif
        if (k == wait_cycles) prod_ready = 1'b1;
        tick();
      end
      prod_ready = 1'b0;
      checks++; if (prod_valid !== 1'b0) begin errors++; $display("[TB] FAIL rand_release %0d: got %b expected 0", n, prod_valid); end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL rand_overrun: got %b expected 0", overrun); end
  endtask

`ifdef SPM_DESER_PARITY_EN
  task automatic test_parity();
    prod_ready = 1'b0;
    drive_stream(ref_product(5, 3), -1);
    checks++; if (prod_parity !== 1'b0) begin errors++; $display("[TB] FAIL parity_0f: got %b expected 0", prod_parity); end
    prod_ready = 1'b1;
    tick();
    prod_ready = 1'b0;
    drive_stream(ref_product(7, 1), -1);
    checks++; if (prod_parity !== 1'b1) begin errors++; $display("[TB] FAIL parity_07: got %b expected 1", prod_parity); end
    prod_ready = 1'b1;
    tick();
    prod_ready = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_mid_reset();
    test_random();
`ifdef SPM_DESER_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spm_prod_deser.md
SPM_PROD_DESER -- requirements
Module: spm_prod_deser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the multiplicand width; the product is PW = 2*WIDTH bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: single-cycle pulse marking product bit 0 on p in the same cycle.
REQ-005 The block SHALL have port p, input, 1 bit: serial product bit from the spm array, LSB-first, one bit per cycle.
REQ-006 The block SHALL have port busy, output, 1 bit: high while in CAPTURE.
REQ-007 The block SHALL have port prod_valid, output, 1 bit: high while a completed product is held.
REQ-008 The block SHALL have port prod_ready, input, 1 bit: consumer accepts prod when prod_valid and prod_ready are both high.
REQ-009 The block SHALL have port prod, output, PW bits: the assembled product, stable while prod_valid is high.
REQ-010 The block SHALL have port overrun, output, 1 bit: sticky, set when a start is dropped.

Function
REQ-011 The FSM SHALL have states IDLE, CAPTURE and HOLD.
REQ-012 In IDLE, start=1 SHALL sample p as bit 0, load bit counter = 1 and enter CAPTURE; start=0 SHALL keep IDLE.
REQ-013 In CAPTURE, each cycle SHALL write p into prod bit [counter] and increment the counter (width clog2(PW)+1).
REQ-014 When bit PW-1 is written, the FSM SHALL enter HOLD; prod_valid SHALL rise the next cycle, PW cycles after the start cycle.
REQ-015 In HOLD, prod_valid and prod_ready both high SHALL complete the transfer: go to IDLE, or straight to CAPTURE with bit 0 sampled if start is high in the same cycle (zero-bubble back-to-back).
REQ-016 A start in CAPTURE, or in HOLD without a same-cycle handshake, SHALL be ignored and SHALL set overrun; the capture and held data SHALL be unaffected.
REQ-017 prod_valid SHALL NOT deassert without a handshake, and prod SHALL NOT change while prod_valid is high.
REQ-018 overrun SHALL clear only on reset.
REQ-019 Unwritten prod bits SHALL keep their previous value; only prod_valid qualifies prod.

Reset
REQ-020 Asserting rst (low) SHALL immediately force IDLE, counter=0, prod=0, prod_valid=0, busy=0, overrun=0, including mid-CAPTURE and mid-HOLD; a partial product SHALL be discarded.
REQ-021 On the first clk edge after rst deasserts, the block SHALL accept a start.

Configuration
REQ-022 With SPM_DESER_PARITY_EN defined, the block SHALL add output prod_parity (1 bit): XOR of all PW bits of prod, registered with prod and valid with prod_valid, reset 0.
REQ-023 With SPM_DESER_PARITY_EN undefined, the block SHALL have no prod_parity port and no parity logic.

Structure
REQ-024 Package spm_pkg SHALL hold the FSM state enum (spm_deser_state_t) and the default WIDTH constant (SPM_WIDTH = 32).
REQ-025 The block SHALL be one module with no sub-module; the counter and shift path are inline.

Verification (WIDTH=4, PW=8)
REQ-026 The bench SHALL apply start with p stream 1,1,1,1,0,0,0,0 (x=5, y=3) and hold prod_ready=1; prod_valid SHALL go high 8 cycles after start with prod=8'h0F, then drop after 1 cycle.
REQ-027 The bench SHALL complete a capture of 8'hE1 (x=15, y=15) with prod_ready=0 for 5 cycles; prod SHALL stay 8'hE1 with prod_valid=1 throughout, and the handshake on cycle 6 SHALL return the FSM to IDLE.
REQ-028 The bench SHALL pulse start at bit 3 of a capture; overrun SHALL read 1, and the original product SHALL complete correctly.
REQ-029 The bench SHALL assert start, prod_valid and prod_ready in the same cycle; the next product 8'h06 SHALL appear after 8 cycles with no dropped bit and overrun=0.
REQ-030 The bench SHALL assert rst low at bit 5 of a capture; all outputs SHALL read 0 immediately, and a fresh capture of 8'h0F afterwards SHALL complete correctly.
REQ-031 With SPM_DESER_PARITY_EN defined, a product of 8'h0F SHALL give prod_parity=0 and 8'h07 SHALL give prod_parity=1.
